// File: rtl/au_pkg.sv
// Shared types and opcode encodings for the sequential arithmetic unit.
package au_pkg;

   localparam logic [1:0] AU_ENC_ADD = 2'b00;
   localparam logic [1:0] AU_ENC_SUB = 2'b01;
   localparam logic [1:0] AU_ENC_MUL = 2'b10;
   localparam logic [1:0] AU_ENC_DIV = 2'b11;

   typedef enum logic [1:0] {
      AU_ADD = AU_ENC_ADD,
      AU_SUB = AU_ENC_SUB,
      AU_MUL = AU_ENC_MUL,
      AU_DIV = AU_ENC_DIV
   } au_op_t;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIX,
      DONE
   } au_state_t;

endpackage

// File: rtl/arith_unit_seq_if.sv
// Operand/result bus between the keypad controller and the arithmetic unit.
//
// Handshake: Start is sampled only while Busy is low (IDLE or the Done
// cycle); operands and Operation are captured on that edge. Busy stays high
// until the Done pulse, during which Start is ignored and not queued. Done is
// a one-cycle pulse, never high together with Busy, and Result, Remainder,
// OVR and DivZero are valid from that cycle until the next Done.
interface arith_unit_seq_if
   import au_pkg::*;
#(
   parameter int WIDTH = 8
);
   logic                 Start;
   au_op_t               Operation;
   logic [2*WIDTH-1:0]   OperandA;
   logic [WIDTH-1:0]     OperandB;
   logic                 Busy;
   logic                 Done;
   logic [2*WIDTH-1:0]   Result;
   logic [WIDTH-1:0]     Remainder;
   logic                 OVR;
   logic                 DivZero;

   modport master (
      output Start, Operation, OperandA, OperandB,
      input  Busy, Done, Result, Remainder, OVR, DivZero
   );

   modport slave (
      input  Start, Operation, OperandA, OperandB,
      output Busy, Done, Result, Remainder, OVR, DivZero
   );
endinterface

// File: rtl/au_seq_core.sv
// Shared 2W accumulator with one adder/subtractor: shift-add multiply of
// magnitudes (hi:lo = partial product:multiplier) and restoring divide
// (hi:lo = partial remainder:dividend/quotient), one bit per step.
module au_seq_core
   import au_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               Clock,
   input  logic               Clear_n,
   input  logic               load,
   input  logic [2*WIDTH-1:0] load_val,
   input  logic               step,
   input  logic               is_div,
   input  logic [WIDTH-1:0]   operand,
   output logic [2*WIDTH-1:0] acc
);
   localparam logic [WIDTH+1:0] ONE = {{(WIDTH+1){1'b0}}, 1'b1};

   logic [WIDTH-1:0]   hi;
   logic [WIDTH-1:0]   lo;
   logic [WIDTH:0]     x;
   logic [WIDTH+1:0]   y_ext;
   logic [WIDTH+1:0]   sum;
   logic [2*WIDTH-1:0] acc_next;

   assign hi = acc[2*WIDTH-1:WIDTH];
   assign lo = acc[WIDTH-1:0];

   // One iteration: divide shifts left and trial-subtracts, multiply adds and shifts right.
   always_comb begin
      x        = '0;
      y_ext    = '0;
      sum      = '0;
      acc_next = acc;
      if (is_div) begin
         x   = {hi, lo[WIDTH-1]};
         y_ext = ~{2'b00, operand};
         sum = {1'b0, x} + y_ext + ONE;
         // A negative difference means the divisor did not fit: restore.
         if (!sum[WIDTH+1]) acc_next = {sum[WIDTH-1:0], lo[WIDTH-2:0], 1'b1};
         else               acc_next = {x[WIDTH-1:0], lo[WIDTH-2:0], 1'b0};
      end else begin
         x     = {1'b0, hi};
         y_ext = lo[0] ? {2'b00, operand} : '0;
         sum   = {1'b0, x} + y_ext;
         acc_next = {sum[WIDTH:0], lo[WIDTH-1:1]};
      end
   end

   // Accumulator register: loaded on accept, advanced once per RUN cycle.
   always_ff @(posedge Clock) begin
      if (!Clear_n)  acc <= '0;
      else if (load) acc <= load_val;
      else if (step) acc <= acc_next;
   end
endmodule

// File: rtl/arith_unit_seq.sv
// Sequential signed add/sub/mul/div unit with Start/Busy/Done handshake.
// Single-cycle ops (add, sub, divide by zero) go straight to FIX, so every
// operation produces its results in FIX and pulses Done in DONE.
module arith_unit_seq
   import au_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               Clock,
   input  logic               Clear_n,
   arith_unit_seq_if.slave    bus,
   output au_state_t          dbg_state
);
   localparam int W2 = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] HALF      = {1'b1, {(WIDTH-1){1'b0}}};

   au_state_t        state, state_next;
   logic [CW-1:0]    cnt;
   au_op_t           op_q;
   logic [W2-1:0]    a_q;
   logic [WIDTH-1:0] b_q;
   logic             accept, short_op;

   logic [WIDTH-1:0] in_b_mag;
   logic [W2-1:0]    in_a_mag2, load_val;
   logic [WIDTH-1:0] a_lo_q, a_mag_q, b_mag_q;
   logic [W2-1:0]    a_mag2_q, core_acc;

   logic [W2-1:0]    fix_result;
   logic [WIDTH-1:0] fix_rem;
   logic             fix_ovr, fix_divz;
   logic [WIDTH:0]   as_sum;
   logic [WIDTH-1:0] q, r, qs;
   logic             neg, q_ovf;

   assign accept   = bus.Start && (state == IDLE || state == DONE);
   assign short_op = (bus.Operation == AU_ADD) || (bus.Operation == AU_SUB) ||
                     (bus.Operation == AU_DIV && bus.OperandB == '0);

   assign in_b_mag  = bus.OperandB[WIDTH-1] ? -bus.OperandB : bus.OperandB;
   assign in_a_mag2 = bus.OperandA[W2-1] ? -bus.OperandA : bus.OperandA;
   assign load_val  = (bus.Operation == AU_DIV) ? in_a_mag2 : {{WIDTH{1'b0}}, in_b_mag};

   assign a_lo_q   = a_q[WIDTH-1:0];
   assign a_mag_q  = a_lo_q[WIDTH-1] ? -a_lo_q : a_lo_q;
   assign b_mag_q  = b_q[WIDTH-1] ? -b_q : b_q;
   assign a_mag2_q = a_q[W2-1] ? -a_q : a_q;

   au_seq_core #(.WIDTH(WIDTH)) u_core (
      .Clock    (Clock),
      .Clear_n  (Clear_n),
      .load     (accept),
      .load_val (load_val),
      .step     (state == RUN),
      .is_div   (op_q == AU_DIV),
      .operand  ((op_q == AU_DIV) ? b_mag_q : a_mag_q),
      .acc      (core_acc)
   );

   // State, iteration counter and operand capture.
   always_ff @(posedge Clock) begin
      if (!Clear_n) begin
         state <= IDLE;
         cnt   <= '0;
         op_q  <= AU_ADD;
         a_q   <= '0;
         b_q   <= '0;
      end else begin
         state <= state_next;
         if (accept) begin
            op_q <= bus.Operation;
            a_q  <= bus.OperandA;
            b_q  <= bus.OperandB;
            cnt  <= '0;
         end else if (state == RUN) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // Next-state logic; a Start in the Done cycle is accepted like one in IDLE.
   always_comb begin
      state_next = state;
      case (state)
         IDLE, DONE: begin
            if (accept) state_next = short_op ? FIX : RUN;
            else        state_next = IDLE;
         end
         RUN:     if (cnt == LAST_ITER) state_next = FIX;
         FIX:     state_next = DONE;
         default: state_next = IDLE;
      endcase
   end

   // Final results: add/sub directly, sign correction for mul/div, range check for div.
   always_comb begin
      fix_result = '0;
      fix_rem    = '0;
      fix_ovr    = 1'b0;
      fix_divz   = 1'b0;
      as_sum     = '0;
      q          = core_acc[WIDTH-1:0];
      r          = core_acc[W2-1:WIDTH];
      qs         = '0;
      neg        = 1'b0;
      q_ovf      = 1'b0;
      case (op_q)
         AU_ADD, AU_SUB: begin
            if (op_q == AU_SUB) as_sum = {a_lo_q[WIDTH-1], a_lo_q} - {b_q[WIDTH-1], b_q};
            else                as_sum = {a_lo_q[WIDTH-1], a_lo_q} + {b_q[WIDTH-1], b_q};
            fix_result = {{(WIDTH-1){as_sum[WIDTH]}}, as_sum};
            fix_ovr    = as_sum[WIDTH] ^ as_sum[WIDTH-1];
         end
         AU_MUL: begin
            neg        = a_lo_q[WIDTH-1] ^ b_q[WIDTH-1];
            fix_result = neg ? -core_acc : core_acc;
         end
         default: begin
            if (b_q == '0) begin
               fix_divz = 1'b1;
               fix_ovr  = 1'b1;
            end else begin
               neg = a_q[W2-1] ^ b_q[WIDTH-1];
               // A high half not below the divisor means the quotient needs more than WIDTH bits.
               q_ovf = (a_mag2_q[W2-1:WIDTH] >= b_mag_q) || (neg ? (q > HALF) : (q >= HALF));
               if (q_ovf) begin
                  fix_ovr = 1'b1;
               end else begin
                  qs         = neg ? -q : q;
                  fix_result = {{WIDTH{qs[WIDTH-1]}}, qs};
                  fix_rem    = a_q[W2-1] ? -r : r;
               end
            end
         end
      endcase
   end

   // Output registers: loaded in FIX, held until the next FIX.
   always_ff @(posedge Clock) begin
      if (!Clear_n) begin
         bus.Result    <= '0;
         bus.Remainder <= '0;
         bus.OVR       <= 1'b0;
         bus.DivZero   <= 1'b0;
      end else if (state == FIX) begin
         bus.Result    <= fix_result;
         bus.Remainder <= fix_rem;
         bus.OVR       <= fix_ovr;
         bus.DivZero   <= fix_divz;
      end
   end

   assign bus.Busy  = (state == RUN) || (state == FIX);
   assign bus.Done  = (state == DONE);
   assign dbg_state = state;
endmodule

// File: tb/tb_arith_unit_seq.sv
// Directed bench for arith_unit_seq at WIDTH=8.
module tb_arith_unit_seq;
   import au_pkg::*;

   logic      Clock;
   logic      Clear_n;
   au_state_t dbg_state;
   int        errors;
   int        checks;

   arith_unit_seq_if #(.WIDTH(8)) bus ();

   arith_unit_seq #(.WIDTH(8)) dut (
      .Clock     (Clock),
      .Clear_n   (Clear_n),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // Clock and reset defaults
   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   // Present an operation for one accepting edge, then scramble the inputs.
   task automatic start_op(input au_op_t op, input logic [15:0] a, input logic [7:0] b);
      @(negedge Clock);
      bus.Start     = 1'b1;
      bus.Operation = op;
      bus.OperandA  = a;
      bus.OperandB  = b;
      @(posedge Clock);
      #1;
      bus.Start     = 1'b0;
      bus.OperandA  = 16'($urandom_range(0, 65535));
      bus.OperandB  = 8'($urandom_range(0, 255));
      bus.Operation = au_op_t'(2'($urandom_range(0, 3)));
   endtask

   // Count edges until Done (lat=-1 on timeout); Busy must be high until then.
   task automatic wait_done(output int lat, output bit busy_ok);
      lat     = -1;
      busy_ok = 1'b1;
      if (!bus.Busy) busy_ok = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge Clock);
         #1;
         if (bus.Done) begin
            if (bus.Busy) busy_ok = 1'b0;
            lat = i;
            break;
         end
         if (!bus.Busy) busy_ok = 1'b0;
      end
   endtask

   task automatic test_reset();
      Clear_n = 1'b0;
      repeat (2) @(posedge Clock);
      #1;
      checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.Busy); end
      checks++; if (bus.Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.Done); end
      checks++; if (bus.Result !== 16'h0000) begin errors++; $display("FAIL reset_result: got %h expected 0000", bus.Result); end
      checks++; if (bus.Remainder !== 8'h00) begin errors++; $display("FAIL reset_rem: got %h expected 00", bus.Remainder); end
      checks++; if (bus.OVR !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b expected 0", bus.OVR); end
      checks++; if (bus.DivZero !== 1'b0) begin errors++; $display("FAIL reset_divz: got %b expected 0", bus.DivZero); end
      checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected IDLE", dbg_state); end
      @(negedge Clock);
      Clear_n = 1'b1;
   endtask

   task automatic test_add_sub();
      int lat;
      bit bok;
      start_op(AU_ADD, 16'd100, 8'd50);
      wait_done(lat, bok);
      checks++; if (lat != 1) begin errors++; $display("FAIL add_latency: got %0d expected 1", lat); end
      checks++; if (!bok) begin errors++; $display("FAIL add_busy: got 0 expected 1"); end
      checks++; if (bus.Result !== 16'h0096) begin errors++; $display("FAIL add_result: got %h expected 0096", bus.Result); end
      checks++; if (bus.OVR !== 1'b1) begin errors++; $display("FAIL add_ovr: got %b expected 1", bus.OVR); end
      checks++; if (bus.Remainder !== 8'h00) begin errors++; $display("FAIL add_rem: got %h expected 00", bus.Remainder); end
      // Outputs hold and Done is a single pulse.
      repeat (3) @(posedge Clock);
      #1;
      checks++; if (bus.Done !== 1'b0) begin errors++; $display("FAIL add_done_pulse: got %b expected 0", bus.Done); end
      checks++; if (bus.Result !== 16'h0096) begin errors++; $display("FAIL add_hold: got %h expected 0096", bus.Result); end

      start_op(AU_SUB, 16'd5, 8'd10);
      wait_done(lat, bok);
      checks++; if (lat != 1) begin errors++; $display("FAIL sub_latency: got %0d expected 1", lat); end
      checks++; if (bus.Result !== 16'hFFFB) begin errors++; $display("FAIL sub_result: got %h expected FFFB", bus.Result); end
      checks++; if (bus.OVR !== 1'b0) begin errors++; $display("FAIL sub_ovr: got %b expected 0", bus.OVR); end

      // -128 - 1 = -129: exact 9-bit result, low 8 bits overflow.
      start_op(AU_SUB, 16'h0080, 8'h01);
      wait_done(lat, bok);
      checks++; if (bus.Result !== 16'hFF7F) begin errors++; $display("FAIL sub_min_result: got %h expected FF7F", bus.Result); end
      checks++; if (bus.OVR !== 1'b1) begin errors++; $display("FAIL sub_min_ovr: got %b expected 1", bus.OVR); end
   endtask

   task automatic test_mul();
      int lat;
      bit bok;
      start_op(AU_MUL, 16'h00FD, 8'd7);
      wait_done(lat, bok);
      checks++; if (lat != 9) begin errors++; $display("FAIL mul_latency: got %0d expected 9", lat); end
      checks++; if (!bok) begin errors++; $display("FAIL mul_busy: got 0 expected 1"); end
      checks++; if (bus.Result !== 16'hFFEB) begin errors++; $display("FAIL mul_neg_result: got %h expected FFEB", bus.Result); end
      checks++; if (bus.OVR !== 1'b0) begin errors++; $display("FAIL mul_ovr: got %b expected 0", bus.OVR); end

      start_op(AU_MUL, 16'h0080, 8'h80);
      wait_done(lat, bok);
      checks++; if (bus.Result !== 16'h4000) begin errors++; $display("FAIL mul_minmin: got %h expected 4000", bus.Result); end

      start_op(AU_MUL, 16'h007F, 8'h80);
      wait_done(lat, bok);
      checks++; if (bus.Result !== 16'hC080) begin errors++; $display("FAIL mul_maxmin: got %h expected C080", bus.Result); end
   endtask

   task automatic test_div();
      int lat;
      bit bok;
      start_op(AU_DIV, 16'hFF9C, 8'd7);
      wait_done(lat, bok);
      checks++; if (lat != 9) begin errors++; $display("FAIL div_latency: got %0d expected 9", lat); end
      checks++; if (!bok) begin errors++; $display("FAIL div_busy: got 0 expected 1"); end
      checks++; if (bus.Result !== 16'hFFF2) begin errors++; $display("FAIL div_quot: got %h expected FFF2", bus.Result); end
      checks++; if (bus.Remainder !== 8'hFE) begin errors++; $display("FAIL div_rem: got %h expected FE", bus.Remainder); end
      checks++; if (bus.OVR !== 1'b0) begin errors++; $display("FAIL div_ovr: got %b expected 0", bus.OVR); end

      // 100 / -7 = -14 remainder +2.
      start_op(AU_DIV, 16'd100, 8'hF9);
      wait_done(lat, bok);
      checks++; if (bus.Result !== 16'hFFF2) begin errors++; $display("FAIL div_negb_quot: got %h expected FFF2", bus.Result); end
      checks++; if (bus.Remainder !== 8'h02) begin errors++; $display("FAIL div_negb_rem: got %h expected 02", bus.Remainder); end

      start_op(AU_DIV, 16'h7FFF, 8'd1);
      wait_done(lat, bok);
      checks++; if (bus.OVR !== 1'b1) begin errors++; $display("FAIL div_big_ovr: got %b expected 1", bus.OVR); end
      checks++; if (bus.Result !== 16'h0000) begin errors++; $display("FAIL div_big_result: got %h expected 0000", bus.Result); end
      checks++; if (bus.Remainder !== 8'h00) begin errors++; $display("FAIL div_big_rem: got %h expected 00", bus.Remainder); end

      // -1024 / 8 = -128 fits; +1024 / 8 = +128 does not.
      start_op(AU_DIV, 16'hFC00, 8'd8);
      wait_done(lat, bok);
      checks++; if (bus.Result !== 16'hFF80) begin errors++; $display("FAIL div_min_quot: got %h expected FF80", bus.Result); end
      checks++; if (bus.OVR !== 1'b0) begin errors++; $display("FAIL div_min_ovr: got %b expected 0", bus.OVR); end

      start_op(AU_DIV, 16'h0400, 8'd8);
      wait_done(lat, bok);
      checks++; if (bus.OVR !== 1'b1) begin errors++; $display("FAIL div_pos128_ovr: got %b expected 1", bus.OVR); end
      checks++; if (bus.Result !== 16'h0000) begin errors++; $display("FAIL div_pos128_result: got %h expected 0000", bus.Result); end
   endtask

   task automatic test_div_zero();
      int lat;
      bit bok;
      start_op(AU_DIV, 16'h0010, 8'd0);
      wait_done(lat, bok);
      checks++; if (lat != 1) begin errors++; $display("FAIL divz_latency: got %0d expected 1", lat); end
      checks++; if (bus.DivZero !== 1'b1) begin errors++; $display("FAIL divz_flag: got %b expected 1", bus.DivZero); end
      checks++; if (bus.OVR !== 1'b1) begin errors++; $display("FAIL divz_ovr: got %b expected 1", bus.OVR); end
      checks++; if (bus.Result !== 16'h0000) begin errors++; $display("FAIL divz_result: got %h expected 0000", bus.Result); end
      checks++; if (bus.Remainder !== 8'h00) begin errors++; $display("FAIL divz_rem: got %h expected 00", bus.Remainder); end

      start_op(AU_ADD, 16'd1, 8'd1);
      wait_done(lat, bok);
      checks++; if (bus.DivZero !== 1'b0) begin errors++; $display("FAIL divz_clear: got %b expected 0", bus.DivZero); end
      checks++; if (bus.Result !== 16'h0002) begin errors++; $display("FAIL divz_next_result: got %h expected 0002", bus.Result); end
   endtask

   task automatic test_busy_ignored();
      int lat;
      int extra_done;
      start_op(AU_MUL, 16'd5, 8'd6);
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge Clock);
         if (i == 2 || i == 5) begin
            bus.Start     = 1'b1;
            bus.Operation = AU_ADD;
            bus.OperandA  = 16'd1;
            bus.OperandB  = 8'd1;
         end else begin
            bus.Start = 1'b0;
         end
         @(posedge Clock);
         #1;
         if (bus.Done) begin
            lat = i;
            break;
         end
      end
      bus.Start = 1'b0;
      checks++; if (lat != 9) begin errors++; $display("FAIL busy_ign_latency: got %0d expected 9", lat); end
      checks++; if (bus.Result !== 16'h001E) begin errors++; $display("FAIL busy_ign_result: got %h expected 001E", bus.Result); end
      extra_done = 0;
      repeat (6) begin
         @(posedge Clock);
         #1;
         if (bus.Done) extra_done++;
      end
      checks++; if (extra_done != 0) begin errors++; $display("FAIL busy_ign_queued: got %0d extra Done expected 0", extra_done); end
   endtask

   task automatic test_back_to_back();
      int lat;
      bit bok;
      @(negedge Clock);
      bus.Start     = 1'b1;
      bus.Operation = AU_ADD;
      bus.OperandA  = 16'd3;
      bus.OperandB  = 8'd4;
      @(posedge Clock);
      #1;
      // Start stays high; the next operation is presented while the add runs.
      bus.Operation = AU_MUL;
      bus.OperandA  = 16'd2;
      bus.OperandB  = 8'hFB;
      wait_done(lat, bok);
      checks++; if (lat != 1) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 1", lat); end
      checks++; if (bus.Result !== 16'h0007) begin errors++; $display("FAIL b2b_first_result: got %h expected 0007", bus.Result); end
      @(posedge Clock);
      #1;
      bus.Start = 1'b0;
      checks++; if (bus.Busy !== 1'b1) begin errors++; $display("FAIL b2b_no_idle: got %b expected 1", bus.Busy); end
      wait_done(lat, bok);
      checks++; if (lat != 9) begin errors++; $display("FAIL b2b_second_latency: got %0d expected 9", lat); end
      checks++; if (bus.Result !== 16'hFFF6) begin errors++; $display("FAIL b2b_second_result: got %h expected FFF6", bus.Result); end
   endtask

   task automatic test_reset_mid();
      int seen_done;
      start_op(AU_MUL, 16'd5, 8'd6);
      repeat (4) @(posedge Clock);
      @(negedge Clock);
      Clear_n   = 1'b0;
      bus.Start = 1'b1;
      bus.Operation = AU_ADD;
      @(posedge Clock);
      #1;
      checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b expected 0", bus.Busy); end
      checks++; if (bus.Done !== 1'b0) begin errors++; $display("FAIL mid_rst_done: got %b expected 0", bus.Done); end
      checks++; if (bus.Result !== 16'h0000) begin errors++; $display("FAIL mid_rst_result: got %h expected 0000", bus.Result); end
      checks++; if (bus.Remainder !== 8'h00 || bus.OVR !== 1'b0 || bus.DivZero !== 1'b0) begin
         errors++; $display("FAIL mid_rst_flags: got rem=%h ovr=%b divz=%b expected 00/0/0", bus.Remainder, bus.OVR, bus.DivZero);
      end
      checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL mid_rst_state: got %0d expected IDLE", dbg_state); end
      @(negedge Clock);
      Clear_n   = 1'b1;
      bus.Start = 1'b0;
      seen_done = 0;
      repeat (15) begin
         @(posedge Clock);
         #1;
         if (bus.Done) seen_done++;
      end
      checks++; if (seen_done != 0) begin errors++; $display("FAIL mid_rst_no_done: got %0d Done expected 0", seen_done); end
   endtask

   // Test sequence and final report
   initial begin
      errors        = 0;
      checks        = 0;
      Clear_n       = 1'b0;
      bus.Start     = 1'b0;
      bus.Operation = AU_ADD;
      bus.OperandA  = '0;
      bus.OperandB  = '0;
      test_reset();
      test_add_sub();
      test_mul();
      test_div();
      test_div_zero();
      test_busy_ignored();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
